// File: rtl/hpi_pkg.sv
// Shared constants and types for the CY7C67200 HPI access sequencer.
package hpi_pkg;

   localparam logic [1:0] HPI_REG_DATA   = 2'd0;
   localparam logic [1:0] HPI_REG_MBX    = 2'd1;
   localparam logic [1:0] HPI_REG_ADDR   = 2'd2;
   localparam logic [1:0] HPI_REG_STATUS = 2'd3;

   localparam int HPI_IO_LAT = 2;

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} hpi_st_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/hpi_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester that did not win last.
module hpi_rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] valid_i,
   input  logic       en_i,
   output logic       gnt_idx_o,
   output logic       gnt_valid_o
);

   logic last_q;

   always_comb begin
      gnt_idx_o   = (valid_i == 2'b11) ? ~last_q : valid_i[1];
      gnt_valid_o = en_i & (|valid_i);
   end

   // Starting at 1 lets requester 0 win the first tie.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else if (gnt_valid_o) begin
         last_q <= gnt_idx_o;
      end
   end

endmodule

// File: rtl/hpi_access_ctrl.sv
// Sequences HPI memory bursts and mailbox accesses for two requesters onto hpi_io_intf.
// state  | meaning
// IDLE   | arbitrate; SETUP  | cs low, address/data set up; STROBE | r or w low
// HOLD   | io_intf latency, read capture; GAP | cs high between accesses
module hpi_access_ctrl
   import hpi_pkg::*;
#(
   parameter int STROBE_CYC = 2,
   parameter int GAP_CYC    = 1,
   parameter int LEN_W      = 8
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0]            req_write,
   input  logic [1:0]            req_mbx,
   input  logic [1:0][15:0]      req_addr,
   input  logic [1:0][LEN_W-1:0] req_len,
   input  logic [1:0][15:0]      req_wdata,
   output logic                  rsp_id,
   output logic                  wdata_ack,
   output logic [15:0]           rdata,
   output logic                  rdata_valid,
   output logic                  done,
   output logic                  busy,
   output logic [1:0]            hpi_address,
   output logic [15:0]           hpi_data_out,
   input  logic [15:0]           hpi_data_in,
   output logic                  hpi_r,
   output logic                  hpi_w,
   output logic                  hpi_cs
);

   localparam int CNT_MAX = max3(STROBE_CYC, GAP_CYC, HPI_IO_LAT) - 1;
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HPI_IO_LAT - 1);
   localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);

   hpi_st_e          st_q;
   logic             id_q;
   logic             write_q;
   logic             addr_ph_q;
   logic [LEN_W-1:0] words_q;
   logic [CNT_W-1:0] cnt_q;
   logic             cs_q, r_q, w_q;
   logic [1:0]       hpi_address_q;
   logic [15:0]      data_q;
   logic             wack_q, rvalid_q, done_q, busy_q;
   logic [15:0]      rdata_q;
   logic             gnt_idx, gnt_valid;

   hpi_rr_arb2 u_arb (
      .clk_i       (Clk),
      .rst_i       (Reset),
      .valid_i     (req_valid),
      .en_i        ((st_q == IDLE) && !Reset),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   assign req_ready = gnt_valid ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         st_q          <= IDLE;
         id_q          <= 1'b0;
         write_q       <= 1'b0;
         addr_ph_q     <= 1'b0;
         words_q       <= '0;
         cnt_q         <= '0;
         cs_q          <= 1'b1;
         r_q           <= 1'b1;
         w_q           <= 1'b1;
         hpi_address_q <= 2'd0;
         data_q        <= 16'd0;
         wack_q        <= 1'b0;
         rvalid_q      <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         rdata_q       <= 16'd0;
      end else begin
         wack_q   <= 1'b0;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         case (st_q)
            IDLE: begin
               if (gnt_valid) begin
                  st_q    <= SETUP;
                  id_q    <= gnt_idx;
                  write_q <= req_write[gnt_idx];
                  words_q <= req_mbx[gnt_idx] ? '0 : req_len[gnt_idx];
                  busy_q  <= 1'b1;
                  cs_q    <= 1'b0;
                  // Mailbox skips the address phase and goes straight to its data word.
                  if (req_mbx[gnt_idx]) begin
                     addr_ph_q     <= 1'b0;
                     hpi_address_q <= HPI_REG_MBX;
                     data_q        <= req_wdata[gnt_idx];
                     wack_q        <= req_write[gnt_idx];
                  end else begin
                     addr_ph_q     <= 1'b1;
                     hpi_address_q <= HPI_REG_ADDR;
                     data_q        <= req_addr[gnt_idx];
                  end
               end
            end
            SETUP: begin
               st_q  <= STROBE;
               cnt_q <= STROBE_LD;
               if (addr_ph_q || write_q) w_q <= 1'b0;
               else                      r_q <= 1'b0;
            end
            STROBE: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  st_q  <= HOLD;
                  cnt_q <= HOLD_LD;
                  r_q   <= 1'b1;
                  w_q   <= 1'b1;
               end
            end
            HOLD: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  st_q  <= GAP;
                  cnt_q <= GAP_LD;
                  cs_q  <= 1'b1;
                  if (!addr_ph_q && !write_q) begin
                     rdata_q  <= hpi_data_in;
                     rvalid_q <= 1'b1;
                  end
               end
            end
            GAP: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else if (addr_ph_q || (words_q != '0)) begin
                  st_q          <= SETUP;
                  cs_q          <= 1'b0;
                  addr_ph_q     <= 1'b0;
                  hpi_address_q <= HPI_REG_DATA;
                  if (!addr_ph_q) words_q <= words_q - LEN_W'(1);
                  if (write_q) begin
                     data_q <= req_wdata[id_q];
                     wack_q <= 1'b1;
                  end
               end else begin
                  st_q   <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: st_q <= IDLE;
         endcase
      end
   end

   assign rsp_id       = id_q;
   assign wdata_ack    = wack_q;
   assign rdata        = rdata_q;
   assign rdata_valid  = rvalid_q;
   assign done         = done_q;
   assign busy         = busy_q;
   assign hpi_address  = hpi_address_q;
   assign hpi_data_out = data_q;
   assign hpi_r        = r_q;
   assign hpi_w        = w_q;
   assign hpi_cs       = cs_q;

endmodule
